// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Brief    : Streams one set of per-LED colours to an LED driver each frame,
//            with pattern generation, frame pacing and a per-LED watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_sequencer #(
    parameter int LEDS_PER_SET  = 5,
    parameter int FRAME_TICKS   = 2500000,
    parameter int TIMEOUT_TICKS = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  base_red,
    input  logic [7:0]  base_green,
    input  logic [7:0]  base_blue,
    input  logic [6:0]  start_index,
    input  logic        drv_finish_led,
    input  logic        drv_finish_set,
    output logic        drv_data_ready,
    output logic [7:0]  drv_red,
    output logic [7:0]  drv_green,
    output logic [7:0]  drv_blue,
    output logic [6:0]  drv_start_index,
    output logic        drv_reset,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        timeout_err
);

    localparam int c_TMAX = (FRAME_TICKS > TIMEOUT_TICKS) ? FRAME_TICKS : TIMEOUT_TICKS;
    localparam int c_TW   = ($clog2(c_TMAX) < 1) ? 1 : $clog2(c_TMAX);

    localparam logic [c_TW-1:0] c_FRAME_LAST   = c_TW'(FRAME_TICKS - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]      c_LAST_IDX     = 4'(LEDS_PER_SET - 1);
    localparam logic [15:0]     c_NLEDS        = 16'(LEDS_PER_SET);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_INIT       = 2'd1;
    localparam logic [1:0] c_SEND       = 2'd2;
    localparam logic [1:0] c_WAIT_FRAME = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [1:0]      r_mode;
    logic [23:0]     r_base;
    logic [3:0]      r_led_idx;
    logic [c_TW-1:0] r_timer;
    logic            r_finish_led_q;
    logic            r_finish_set_q;
    logic            w_led_rise;
    logic            w_set_rise;
    logic            w_timeout;

    // Frame number f selects the pattern phase: blink on f parity, chase on f mod set size.
    function automatic logic [23:0] f_colour(input logic [1:0]  m,
                                             input logic [23:0] base,
                                             input logic [3:0]  k,
                                             input logic [15:0] f);
        logic [15:0] pos;
        pos = f % c_NLEDS;
        case (m)
            2'd0:    f_colour = base;
            2'd1:    f_colour = f[0] ? 24'd0 : base;
            2'd2:    f_colour = ({12'd0, k} == pos) ? base : 24'd0;
            default: f_colour = 24'd0;
        endcase
    endfunction

    assign w_led_rise = drv_finish_led & ~r_finish_led_q;
    assign w_set_rise = drv_finish_set & ~r_finish_set_q;
    assign w_timeout  = (r_state == c_SEND) && !w_set_rise && !w_led_rise &&
                        (r_timer == c_TIMEOUT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:       if (enable) w_next_state = c_INIT;
            c_INIT:       w_next_state = c_SEND;
            c_SEND: begin
                if (w_set_rise)     w_next_state = c_WAIT_FRAME;
                else if (w_timeout) w_next_state = c_INIT;
            end
            c_WAIT_FRAME: if (r_timer == c_FRAME_LAST) w_next_state = enable ? c_INIT : c_IDLE;
            default:      w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_IDLE;
            r_mode          <= 2'd0;
            r_base          <= 24'd0;
            r_led_idx       <= 4'd0;
            r_timer         <= '0;
            r_finish_led_q  <= 1'b0;
            r_finish_set_q  <= 1'b0;
            drv_data_ready  <= 1'b0;
            drv_red         <= 8'd0;
            drv_green       <= 8'd0;
            drv_blue        <= 8'd0;
            drv_start_index <= 7'd0;
            drv_reset       <= 1'b1;
            busy            <= 1'b0;
            frame_count     <= 16'd0;
            timeout_err     <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_finish_led_q <= drv_finish_led;
            r_finish_set_q <= drv_finish_set;
            busy           <= (w_next_state != c_IDLE);
            // INIT always lasts one cycle, so this yields a single-cycle driver reset.
            drv_reset      <= (w_next_state == c_INIT);
            case (r_state)
                c_INIT: begin
                    r_mode          <= mode;
                    r_base          <= {base_red, base_green, base_blue};
                    drv_start_index <= start_index;
                    r_led_idx       <= 4'd0;
                    r_timer         <= '0;
                    drv_data_ready  <= 1'b1;
                    {drv_red, drv_green, drv_blue} <=
                        f_colour(mode, {base_red, base_green, base_blue}, 4'd0, frame_count);
                end
                c_SEND: begin
                    if (w_set_rise) begin
                        drv_data_ready <= 1'b0;
                        frame_count    <= frame_count + 16'd1;
                        r_timer        <= '0;
                    end else if (w_led_rise) begin
                        r_timer <= '0;
                        if (r_led_idx < c_LAST_IDX) begin
                            r_led_idx <= r_led_idx + 4'd1;
                            {drv_red, drv_green, drv_blue} <=
                                f_colour(r_mode, r_base, r_led_idx + 4'd1, frame_count);
                        end
                    end else if (w_timeout) begin
                        timeout_err    <= 1'b1;
                        drv_data_ready <= 1'b0;
                        r_timer        <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_WAIT_FRAME: begin
                    if (r_timer == c_FRAME_LAST) r_timer <= '0;
                    else                         r_timer <= r_timer + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_sequencer
// Brief    : Directed, scoreboard-based bench for led_frame_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_frame_sequencer;

    localparam int N  = 5;
    localparam int FT = 20;
    localparam int TT = 30;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  base_red, base_green, base_blue;
    logic [6:0]  start_index;
    logic        drv_finish_led, drv_finish_set;
    logic        drv_data_ready;
    logic [7:0]  drv_red, drv_green, drv_blue;
    logic [6:0]  drv_start_index;
    logic        drv_reset, busy, timeout_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    led_frame_sequencer #(
        .LEDS_PER_SET  (N),
        .FRAME_TICKS   (FT),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .mode            (mode),
        .base_red        (base_red),
        .base_green      (base_green),
        .base_blue       (base_blue),
        .start_index     (start_index),
        .drv_finish_led  (drv_finish_led),
        .drv_finish_set  (drv_finish_set),
        .drv_data_ready  (drv_data_ready),
        .drv_red         (drv_red),
        .drv_green       (drv_green),
        .drv_blue        (drv_blue),
        .drv_start_index (drv_start_index),
        .drv_reset       (drv_reset),
        .busy            (busy),
        .frame_count     (frame_count),
        .timeout_err     (timeout_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_frame;
    int          cnt;
    bit          ok;
    logic [23:0] sb_q[$];
    logic [1:0]  cur_mode;
    logic [23:0] cur_base;
    logic [6:0]  cur_start;

    function automatic logic [23:0] model_colour(input logic [1:0] m, input logic [23:0] b,
                                                 input int k, input int f);
        case (m)
            2'd0:    return b;
            2'd1:    return ((f % 2) == 0) ? b : 24'd0;
            2'd2:    return (k == (f % N)) ? b : 24'd0;
            default: return 24'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        mode = cur_mode;
        {base_red, base_green, base_blue} = cur_base;
        start_index = cur_start;
    endtask

    task automatic do_reset();
        enable = 1'b0; drv_finish_led = 1'b0; drv_finish_set = 1'b0;
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_frame = 0;
        sb_q.delete();
    endtask

    task automatic wait_ready(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (drv_data_ready === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++; n_fail++;
            $error("FAIL wait_ready: observed=no drv_data_ready expected=drv_data_ready within 300 cycles");
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy !== 1'b0 && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic push_set();
        for (int k = 0; k < N; k++) sb_q.push_back(model_colour(cur_mode, cur_base, k, exp_frame));
    endtask

    task automatic led_step(input int k, input bit pulse);
        logic [23:0] e;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL scoreboard_empty: observed=no entry expected=entry for led%0d", k);
            e = 24'hx;
        end else begin
            e = sb_q.pop_front();
        end
        chk($sformatf("led%0d_colour", k), {8'd0, drv_red, drv_green, drv_blue}, {8'd0, e});
        chk("ready_in_send", drv_data_ready, 1);
        if (pulse) begin
            drv_finish_led = 1'b1;
            @(negedge clk);
            drv_finish_led = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_set(input bit scramble, input bit drop_en);
        bit found;
        wait_ready(found);
        if (!found) return;
        push_set();
        for (int k = 0; k < N; k++) begin
            if (scramble && k == 1) begin
                mode = 2'd3;
                {base_red, base_green, base_blue} = 24'h0;
                start_index = ~cur_start;
            end
            if (drop_en && k == 3) enable = 1'b0;
            led_step(k, 1'b1);
        end
        drv_finish_set = 1'b1;
        @(negedge clk);
        drv_finish_set = 1'b0;
        exp_frame++;
        chk("start_index_latched", drv_start_index, cur_start);
        apply_inputs();
        chk("ready_low_after_set", drv_data_ready, 0);
        chk("frame_count", frame_count, exp_frame);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; drv_finish_led = 1'b0; drv_finish_set = 1'b0;
        cur_mode = 2'd0; cur_base = 24'h0; cur_start = 7'd0; apply_inputs();
        exp_frame = 0;

        // Reset values
        @(negedge clk);
        chk("rst_ready", drv_data_ready, 0);
        chk("rst_drv_reset", drv_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame_count, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_colour", {drv_red, drv_green, drv_blue}, 0);
        chk("rst_start", drv_start_index, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("drv_reset_release", drv_reset, 0);
        chk("idle_busy", busy, 0);

        // Solid
        cur_mode = 2'd0; cur_base = 24'h201005; cur_start = 7'd9; apply_inputs();
        enable = 1'b1;
        run_set(1'b0, 1'b0);
        chk("busy_in_wait", busy, 1);
        enable = 1'b0;
        wait_idle(cnt);
        chk("solid_idle", busy, 0);

        // Chase over six frames; inputs scrambled mid-set in frame 2
        do_reset();
        cur_mode = 2'd2; cur_base = 24'hFFFFFF; cur_start = 7'd33; apply_inputs();
        enable = 1'b1;
        for (int f = 0; f < 6; f++) run_set(f == 2, 1'b0);
        enable = 1'b0;
        wait_idle(cnt);

        // Blink over two frames with mid-set input changes
        do_reset();
        cur_mode = 2'd1; cur_base = 24'h123456; cur_start = 7'd100; apply_inputs();
        enable = 1'b1;
        run_set(1'b1, 1'b0);
        run_set(1'b1, 1'b0);
        chk("blink_frames", frame_count, 2);
        enable = 1'b0;
        wait_idle(cnt);

        // Timeout: LED 2 never finished
        do_reset();
        cur_mode = 2'd0; cur_base = 24'h0A0B0C; cur_start = 7'd5; apply_inputs();
        enable = 1'b1;
        wait_ready(ok);
        if (ok) begin
            push_set();
            led_step(0, 1'b1);
            led_step(1, 1'b1);
            led_step(2, 1'b0);
            cnt = 0;
            while (timeout_err !== 1'b1 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("timeout_latency", cnt, TT - 1);
            chk("timeout_err_set", timeout_err, 1);
            chk("timeout_drv_reset", drv_reset, 1);
            chk("timeout_ready_low", drv_data_ready, 0);
            chk("timeout_frame", frame_count, 0);
            sb_q.delete();
            @(negedge clk);
            chk("timeout_reset_pulse_end", drv_reset, 0);
            chk("timeout_resend", drv_data_ready, 1);
            run_set(1'b0, 1'b0);
            chk("timeout_sticky", timeout_err, 1);
        end
        enable = 1'b0;
        wait_idle(cnt);

        // Enable dropped during LED 3
        do_reset();
        cur_mode = 2'd0; cur_base = 24'h445566; cur_start = 7'd1; apply_inputs();
        enable = 1'b1;
        run_set(1'b0, 1'b1);
        chk("drop_busy_wait", busy, 1);
        wait_idle(cnt);
        chk("drop_wait_len", cnt, FT);
        chk("drop_ready", drv_data_ready, 0);
        repeat (10) @(negedge clk);
        chk("drop_stays_idle", busy, 0);
        chk("drop_no_drv_reset", drv_reset, 0);
        chk("drop_frame", frame_count, 1);

        // Asynchronous reset in the middle of a set
        do_reset();
        cur_mode = 2'd0; cur_base = 24'h778899; cur_start = 7'd44; apply_inputs();
        enable = 1'b1;
        run_set(1'b0, 1'b0);
        wait_ready(ok);
        if (ok) begin
            push_set();
            led_step(0, 1'b1);
            led_step(1, 1'b0);
            #2 reset_n = 1'b0;
            #1;
            chk("async_ready", drv_data_ready, 0);
            chk("async_drv_reset", drv_reset, 1);
            chk("async_colour", {drv_red, drv_green, drv_blue}, 0);
            chk("async_start", drv_start_index, 0);
            chk("async_busy", busy, 0);
            chk("async_frame", frame_count, 0);
            chk("async_err", timeout_err, 0);
        end
        sb_q.delete();
        enable = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_async_idle", busy, 0);
        chk("post_async_drv_reset", drv_reset, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
